// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SYNC/LEN/payload/CHECKSUM frames from a UART byte
// stream. Payload bytes are written cut-through to an external buffer RAM.
// The checksum is the mod-256 sum of the LEN byte and all payload bytes.
// Optional feature: define PARSER_STATS_EN to add saturating good/bad packet counters.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         MAX_LEN     = 64,
  parameter int         ADDR_W      = 6,
  parameter int         TIMEOUT_CYC = 4340
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_error,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              pkt_done,
  output logic [7:0]        pkt_len,
  output logic              pkt_error,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [2:0]        state
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3
  } state_t;

  localparam int         TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  state_t            state_q, state_n;
  logic [7:0]        len_q, len_n;
  logic [7:0]        sum_q, sum_n;
  logic [7:0]        idx_q, idx_n;
  logic [TW-1:0]     timer_q, timer_n;
  logic              wr_en_n, done_n, error_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n, pkt_len_n;
  logic [1:0]        code_n;
  logic              timeout;

  // Next-state and next-output decode; abort events outrank incoming bytes.
  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    sum_n     = sum_q;
    idx_n     = idx_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = 1'b0;
    error_n   = 1'b0;
    code_n    = err_code;
    pkt_len_n = pkt_len;
    timeout   = (state_q != S_IDLE) && (timer_q == TIMER_LAST);

    if (state_q == S_IDLE || rx_valid) timer_n = '0;
    else                               timer_n = timer_q + TW'(1);

    if (state_q != S_IDLE && rx_frame_error) begin
      error_n = 1'b1;
      code_n  = 2'd0;
      state_n = S_IDLE;
      timer_n = '0;
    end else if (timeout) begin
      error_n = 1'b1;
      code_n  = 2'd3;
      state_n = S_IDLE;
      timer_n = '0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) state_n = S_LEN;
        end
        S_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            error_n = 1'b1;
            code_n  = 2'd1;
            state_n = S_IDLE;
          end else begin
            len_n   = rx_data;
            sum_n   = rx_data;
            idx_n   = 8'd0;
            state_n = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          wr_en_n   = 1'b1;
          wr_addr_n = idx_q[ADDR_W-1:0];
          wr_data_n = rx_data;
          sum_n     = sum_q + rx_data;
          idx_n     = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_n = S_CHECK;
        end
        S_CHECK: begin
          if (rx_data == sum_q) begin
            done_n    = 1'b1;
            pkt_len_n = len_q;
          end else begin
            error_n = 1'b1;
            code_n  = 2'd2;
          end
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      idx_q     <= 8'd0;
      timer_q   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      pkt_done  <= 1'b0;
      pkt_len   <= 8'd0;
      pkt_error <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      len_q     <= len_n;
      sum_q     <= sum_n;
      idx_q     <= idx_n;
      timer_q   <= timer_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      pkt_done  <= done_n;
      pkt_len   <= pkt_len_n;
      pkt_error <= error_n;
      err_code  <= code_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  assign state = state_q;

`ifdef PARSER_STATS_EN
  // Saturating packet statistics, updated on the same edge as the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_ok_cnt  <= 16'd0;
      pkt_err_cnt <= 16'd0;
    end else begin
      if (done_n && pkt_ok_cnt != 16'hFFFF)   pkt_ok_cnt  <= pkt_ok_cnt + 16'd1;
      if (error_n && pkt_err_cnt != 16'hFFFF) pkt_err_cnt <= pkt_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: directed frames with literal expectations,
// then randomized traffic compared every cycle against a queue-based packet model.
// PARSER_STATS_EN, when defined, also connects and checks the statistics counters.
module tb_uart_frame_parser;
  localparam int         TO   = 60;
  localparam int         MAXL = 64;
  localparam int         AW   = 6;
  localparam logic [7:0] SYNC = 8'hAA;

  logic          clk = 1'b0;
  logic          rst, rx_valid, rx_frame_error;
  logic [7:0]    rx_data;
  logic          wr_en, pkt_done, pkt_error, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, pkt_len;
  logic [1:0]    err_code;
  logic [2:0]    state;
`ifdef PARSER_STATS_EN
  logic [15:0]   pkt_ok_cnt, pkt_err_cnt;
`endif

  uart_frame_parser #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_error(rx_frame_error), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .pkt_error(pkt_error), .err_code(err_code), .busy(busy), .state(state)
`ifdef PARSER_STATS_EN
    , .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Packet model: bytes of the current frame after SYNC (LEN first).
  bit         in_pkt;
  logic [7:0] pkt[$];
  int         quiet;
  logic       exp_wr_en, exp_done, exp_error, exp_busy;
  logic [7:0] exp_wr_addr, exp_wr_data, exp_pkt_len;
  logic [1:0] exp_code;
  logic [2:0] exp_state;
  logic [15:0] exp_ok, exp_errc;

  logic [7:0] mem [0:63];
  int wr_cnt = 0, done_seen = 0, err_seen = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_abort(input logic [1:0] c);
    exp_error = 1'b1;
    exp_code  = c;
    in_pkt    = 1'b0;
    if (exp_errc != 16'hFFFF) exp_errc++;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic fe);
    int n, s;
    exp_wr_en = 1'b0;
    exp_done  = 1'b0;
    exp_error = 1'b0;
    if (r) begin
      in_pkt = 1'b0; pkt.delete(); quiet = 0;
      exp_wr_addr = 0; exp_wr_data = 0; exp_pkt_len = 0; exp_code = 0;
      exp_ok = 0; exp_errc = 0;
    end else if (in_pkt && fe) begin
      model_abort(2'd0);
    end else if (in_pkt && quiet == TO - 1) begin
      model_abort(2'd3);
    end else if (v) begin
      quiet = 0;
      if (!in_pkt) begin
        if (d == SYNC) begin in_pkt = 1'b1; pkt.delete(); end
      end else begin
        pkt.push_back(d);
        n = pkt.size();
        if (n == 1) begin
          if (d == 0 || int'(d) > MAXL) model_abort(2'd1);
        end else if (n == int'(pkt[0]) + 2) begin
          s = 0;
          for (int i = 0; i < n - 1; i++) s += int'(pkt[i]);
          if (8'(s) == d) begin
            exp_done = 1'b1;
            exp_pkt_len = pkt[0];
            if (exp_ok != 16'hFFFF) exp_ok++;
            in_pkt = 1'b0;
          end else model_abort(2'd2);
        end else begin
          exp_wr_en   = 1'b1;
          exp_wr_addr = 8'(n - 2);
          exp_wr_data = d;
        end
      end
    end else if (in_pkt) begin
      quiet++;
    end
    if (!in_pkt) quiet = 0;
    if (!in_pkt)                              exp_state = 3'd0;
    else if (pkt.size() == 0)                 exp_state = 3'd1;
    else if (pkt.size() < int'(pkt[0]) + 1)   exp_state = 3'd2;
    else                                      exp_state = 3'd3;
    exp_busy = (exp_state != 3'd0);
  endtask

  // Per-cycle comparison against the model, plus a log of what the DUT did.
  always @(posedge clk) begin
    #1;
    chk("wr_en", 16'(wr_en), 16'(exp_wr_en));
    if (exp_wr_en) begin
      chk("wr_addr", 16'(wr_addr), 16'(exp_wr_addr[AW-1:0]));
      chk("wr_data", 16'(wr_data), 16'(exp_wr_data));
    end
    chk("pkt_done", 16'(pkt_done), 16'(exp_done));
    chk("pkt_error", 16'(pkt_error), 16'(exp_error));
    chk("pkt_len", 16'(pkt_len), 16'(exp_pkt_len));
    chk("err_code", 16'(err_code), 16'(exp_code));
    chk("busy", 16'(busy), 16'(exp_busy));
    chk("state", 16'(state), 16'(exp_state));
`ifdef PARSER_STATS_EN
    chk("pkt_ok_cnt", pkt_ok_cnt, exp_ok);
    chk("pkt_err_cnt", pkt_err_cnt, exp_errc);
`endif
    if (wr_en === 1'b1) begin mem[wr_addr] = wr_data; wr_cnt++; end
    if (pkt_done === 1'b1) done_seen++;
    if (pkt_error === 1'b1) err_seen++;
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic fe);
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = d; rx_frame_error = fe;
    model_step(r, v, d, fe);
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int w0, kind, len, gap, sum;
    logic [7:0] bytes[$];
    logic [7:0] b;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_error = 1'b0;
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);

    // Good frame: checksum = 03+11+22+33 = 69.
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    idle(1);
    chk("p1_mem0", 16'(mem[0]), 16'h11);
    chk("p1_mem1", 16'(mem[1]), 16'h22);
    chk("p1_mem2", 16'(mem[2]), 16'h33);
    chk("p1_len", 16'(pkt_len), 16'd3);
    chk("p1_done_cnt", 16'(done_seen), 16'd1);
    chk("p1_err_cnt", 16'(err_seen), 16'd0);

    // Bad checksum.
    send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(1);
    chk("p2_error", 16'(pkt_error), 16'd1);
    chk("p2_code", 16'(err_code), 16'd2);
    chk("p2_done_cnt", 16'(done_seen), 16'd1);

    // Bad lengths, then a minimal good frame.
    w0 = wr_cnt;
    send(8'hAA); send(8'h00); idle(1);
    chk("len0_code", 16'(err_code), 16'd1);
    send(8'hAA); send(8'h41); idle(1);
    chk("len41_code", 16'(err_code), 16'd1);
    chk("badlen_errs", 16'(err_seen), 16'd3);
    chk("badlen_nowr", 16'(wr_cnt), 16'(w0));
    send(8'hAA); send(8'h01); send(8'h05); send(8'h06); idle(1);
    chk("p3_done", 16'(pkt_done), 16'd1);
    chk("p3_len", 16'(pkt_len), 16'd1);

    // Timeout, then a stray byte in IDLE.
    send(8'hAA); send(8'h04); send(8'h01);
    idle(TO + 1);
    chk("to_code", 16'(err_code), 16'd3);
    chk("to_busy", 16'(busy), 16'd0);
    chk("to_errs", 16'(err_seen), 16'd4);
    send(8'h55); idle(2);
    chk("stray_errs", 16'(err_seen), 16'd4);
    chk("stray_state", 16'(state), 16'd0);

    // Frame error mid-payload.
    send(8'hAA); send(8'h02); send(8'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b1); idle(1);
    chk("fe_code", 16'(err_code), 16'd0);
    chk("fe_errs", 16'(err_seen), 16'd5);
`ifdef PARSER_STATS_EN
    chk("stats_ok", pkt_ok_cnt, 16'd2);
    chk("stats_err", pkt_err_cnt, 16'd5);
`endif

    // Reset mid-payload.
    send(8'hAA); send(8'h04); send(8'h01); send(8'h02);
    drive(1'b1, 1'b0, 8'h00, 1'b0); idle(2);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_errs", 16'(err_seen), 16'd5);
    chk("rst_dones", 16'(done_seen), 16'd2);

    // Randomized traffic.
    for (int p = 0; p < 300; p++) begin
      bytes.delete();
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        bytes.push_back(8'($urandom));
      end else if (kind == 1) begin
        bytes.push_back(SYNC);
        bytes.push_back(($urandom % 2 == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      end else begin
        len = ($urandom % 4 == 0) ? int'($urandom_range(1, MAXL)) : int'($urandom_range(1, 8));
        bytes.push_back(SYNC);
        bytes.push_back(8'(len));
        sum = len;
        for (int i = 0; i < len; i++) begin
          b = ($urandom % 8 == 0) ? SYNC : 8'($urandom);
          bytes.push_back(b);
          sum += int'(b);
        end
        b = 8'(sum);
        if (kind == 2) b = b ^ 8'($urandom_range(1, 255));
        bytes.push_back(b);
      end
      if ($urandom % 150 == 0) drive(1'b1, 1'b0, 8'h00, 1'b0);
      foreach (bytes[i]) begin
        case ($urandom % 40)
          0:       gap = TO - 1;
          1:       gap = TO - 2;
          2:       gap = TO + 3;
          default: gap = int'($urandom % 3);
        endcase
        idle(gap);
        if ($urandom % 80 == 0) drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, bytes[i], ($urandom % 60 == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
